// File: rtl/e_mdu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : e_mdu_seq_if
//  Description : Bundle between the E-stage control/datapath and the
//                multiply/divide unit.
//                master : start, MDOp, MDWE, MDAddrOp, A, B   (driven by E stage)
//                slave  : busy, HI, LO, rdData               (driven by the MDU)
//  Revision    : 1.0  initial release
// ============================================================================
interface e_mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       MDOp;
    logic             MDWE;
    logic             MDAddrOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic [WIDTH-1:0] rdData;

    modport master (
        output start, MDOp, MDWE, MDAddrOp, A, B,
        input  busy, HI, LO, rdData
    );

    modport slave (
        input  start, MDOp, MDWE, MDAddrOp, A, B,
        output busy, HI, LO, rdData
    );
endinterface
`default_nettype wire

// File: rtl/e_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : e_mdu_seq
//  Description : Multi-cycle multiply/divide unit for the E stage. Holds HI/LO,
//                runs signed/unsigned mult/div with a fixed busy period of
//                MULT_LAT / DIV_LAT cycles, and serves mfhi/mflo/mthi/mtlo.
//  Ports       : clk       rising-edge clock
//                reset_n   asynchronous active-low reset
//                mdu       e_mdu_seq_if.slave (start, MDOp, MDWE, MDAddrOp,
//                          A, B in; busy, HI, LO, rdData out)
//  Options     : MDU_MADD_EN  when defined, MDOp 101 = madd, 110 = maddu
//  Revision    : 1.0  initial release
// ============================================================================
module e_mdu_seq #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    e_mdu_seq_if.slave  mdu
);

    localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT) + 1;

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_LAT - 1);

    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_MULT  = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_DIV   = 3'b100;
`ifdef MDU_MADD_EN
    localparam logic [2:0] c_OP_MADD  = 3'b101;
    localparam logic [2:0] c_OP_MADDU = 3'b110;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;

    // ---------------- request decode ----------------
    logic               w_op_legal;
    logic [c_CNT_W-1:0] w_load;

    always_comb begin
        w_op_legal = 1'b0;
        w_load     = c_MULT_LOAD;
        case (mdu.MDOp)
            c_OP_MULTU, c_OP_MULT: begin
                w_op_legal = 1'b1;
                w_load     = c_MULT_LOAD;
            end
            c_OP_DIVU, c_OP_DIV: begin
                w_op_legal = 1'b1;
                w_load     = c_DIV_LOAD;
            end
`ifdef MDU_MADD_EN
            c_OP_MADD, c_OP_MADDU: begin
                w_op_legal = 1'b1;
                w_load     = c_MULT_LOAD;
            end
`endif
            default: ;
        endcase
    end

    // ---------------- arithmetic on the latched operands ----------------
    // Operands are widened to 2*WIDTH before multiplying; the low 2*WIDTH
    // bits of the product of sign-extended values equal the signed product.
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;

    assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // One unsigned divider serves both flavours: signed division runs on
    // magnitudes and the signs are reapplied afterwards. This also yields
    // the overflow case (most-negative / -1 -> LO = A, HI = 0) naturally,
    // since the magnitude of the most-negative value is representable
    // unsigned and its re-negation wraps back to itself.
    logic             w_sdiv;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_num;
    logic [WIDTH-1:0] w_den;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_sdiv  = (r_op == c_OP_DIV);
    assign w_a_neg = w_sdiv & r_a[WIDTH-1];
    assign w_b_neg = w_sdiv & r_b[WIDTH-1];
    assign w_num   = w_a_neg ? (~r_a + 1'b1) : r_a;
    assign w_den   = w_b_neg ? (~r_b + 1'b1) : r_b;
    assign w_uq    = (w_den == '0) ? '0 : (w_num / w_den);
    assign w_ur    = (w_den == '0) ? '0 : (w_num % w_den);
    assign w_quo   = (w_a_neg ^ w_b_neg) ? (~w_uq + 1'b1) : w_uq;
    assign w_rem   = w_a_neg ? (~w_ur + 1'b1) : w_ur;

`ifdef MDU_MADD_EN
    // Accumulate onto HI/LO as they stand at the final edge.
    logic [2*WIDTH-1:0] w_acc;
    assign w_acc = {r_hi, r_lo} + ((r_op == c_OP_MADD) ? w_prod_s : w_prod_u);
`endif

    logic             w_res_we;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    always_comb begin
        w_res_we = 1'b1;
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            c_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            c_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            c_OP_DIVU, c_OP_DIV: begin
                // divide by zero leaves HI/LO untouched
                if (r_b == '0) begin
                    w_res_we = 1'b0;
                end else begin
                    w_res_hi = w_rem;
                    w_res_lo = w_quo;
                end
            end
`ifdef MDU_MADD_EN
            c_OP_MADD, c_OP_MADDU: {w_res_hi, w_res_lo} = w_acc;
`endif
            default: w_res_we = 1'b0;
        endcase
    end

    // ---------------- control FSM + HI/LO ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'b000;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mdu.start && w_op_legal) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_op    <= mdu.MDOp;
                        r_a     <= mdu.A;
                        r_b     <= mdu.B;
                        r_cnt   <= w_load;
                    end else if (mdu.start && mdu.MDWE) begin
                        // a legal MDOp alongside MDWE takes precedence above
                        if (mdu.MDAddrOp) begin
                            r_hi <= mdu.A;
                        end else begin
                            r_lo <= mdu.A;
                        end
                    end
                end
                S_RUN: begin
                    // requests arriving while running are dropped here
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (w_res_we) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mdu.busy   = r_busy;
    assign mdu.HI     = r_hi;
    assign mdu.LO     = r_lo;
    assign mdu.rdData = mdu.MDAddrOp ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_e_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e_mdu_seq
//  Description : Scoreboard bench for e_mdu_seq. The driver computes expected
//                HI/LO and busy length from a plain-arithmetic model and
//                queues them; a negedge monitor pops and compares whenever an
//                operation retires (busy falls) or an mthi/mtlo lands.
//                Honours MDU_MADD_EN for the madd/no-op case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_e_mdu_seq;

    localparam int WIDTH    = 32;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    e_mdu_seq_if #(.WIDTH(WIDTH)) mdu_if ();

    e_mdu_seq #(
        .WIDTH    (WIDTH),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mdu     (mdu_if)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          errors      = 0;
    int          checks      = 0;
    int          hz_seen     = 0;
    int          hz_expected = 0;
    logic [31:0] m_hi        = '0;
    logic [31:0] m_lo        = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // Returns busy length (0 = op not recognised, nothing happens).
    function automatic int model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          q;
        longint          r;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd1: begin p = 64'(ua * ub); {m_hi, m_lo} = p; return MULT_LAT; end
            3'd2: begin p = 64'(sa * sb); {m_hi, m_lo} = p; return MULT_LAT; end
            3'd3: begin
                if (b != 0) begin
                    m_lo = 32'(ua / ub);
                    m_hi = 32'(ua % ub);
                end
                return DIV_LAT;
            end
            3'd4: begin
                if (b != 0) begin
                    q    = sa / sb;          // truncates toward zero
                    r    = sa - q * sb;      // sign follows dividend
                    m_lo = 32'(q);
                    m_hi = 32'(r);
                end
                return DIV_LAT;
            end
`ifdef MDU_MADD_EN
            3'd5: begin p = 64'(sa * sb); {m_hi, m_lo} = {m_hi, m_lo} + p; return MULT_LAT; end
            3'd6: begin p = 64'(ua * ub); {m_hi, m_lo} = {m_hi, m_lo} + p; return MULT_LAT; end
`endif
            default: return 0;
        endcase
    endfunction

    // ---------------- driver helpers ----------------
    task automatic drive(input logic [2:0] op, input logic we, input logic sel,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        mdu_if.start    = 1'b1;
        mdu_if.MDOp     = op;
        mdu_if.MDWE     = we;
        mdu_if.MDAddrOp = sel;
        mdu_if.A        = a;
        mdu_if.B        = b;
        @(posedge clk); #1;
        mdu_if.start    = 1'b0;
        mdu_if.MDOp     = 3'b000;
        mdu_if.MDWE     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (!mdu_if.busy) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still %b after 40 cycles, required 0", name, mdu_if.busy);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        exp_t e;
        int   lat;
        lat = model_op(op, a, b);
        if (lat > 0) begin
            e.hi = m_hi; e.lo = m_lo; e.lat = lat; e.name = name;
            sb_q.push_back(e);
        end
        chk({name, "_busy_pre"}, 64'(mdu_if.busy), 64'd0);
        drive(op, 1'b0, 1'b0, a, b);
        // busy rises the cycle after the issue edge
        chk({name, "_busy_rise"}, 64'(mdu_if.busy), 64'(lat > 0));
        wait_idle(name);
    endtask

    task automatic do_mt(input logic sel, input logic [31:0] a, input string name);
        exp_t e;
        if (sel) m_hi = a; else m_lo = a;
        e.hi = m_hi; e.lo = m_lo; e.lat = 0; e.name = name;
        sb_q.push_back(e);
        drive(3'b000, 1'b1, sel, a, 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit   busy_prev = 1'b0;
    bit   wr_pend   = 1'b0;
    int   busy_run  = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            busy_prev = 1'b0;
            busy_run  = 0;
            wr_pend   = 1'b0;
        end else begin
            if (wr_pend) begin
                wr_pend = 1'b0;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_write: write landed with empty queue, HI=%h LO=%h", mdu_if.HI, mdu_if.LO);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk({mon_e.name, "_hi"}, 64'(mdu_if.HI), 64'(mon_e.hi));
                    chk({mon_e.name, "_lo"}, 64'(mdu_if.LO), 64'(mon_e.lo));
                end
            end
            if (mdu_if.busy) begin
                busy_run++;
            end else if (busy_prev) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_retire: op retired with empty queue, HI=%h LO=%h", mdu_if.HI, mdu_if.LO);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk({mon_e.name, "_hi"},  64'(mdu_if.HI), 64'(mon_e.hi));
                    chk({mon_e.name, "_lo"},  64'(mdu_if.LO), 64'(mon_e.lo));
                    chk({mon_e.name, "_lat"}, 64'(busy_run),  64'(mon_e.lat));
                end
                busy_run = 0;
            end
            if (mdu_if.start && mdu_if.busy && (mdu_if.MDOp != 3'b000 || mdu_if.MDWE)) begin
                hz_seen++;
                $display("note: HI/LO request while busy at %0t (hazard unit should stall this)", $time);
            end
            if (mdu_if.start && !mdu_if.busy && mdu_if.MDWE && mdu_if.MDOp == 3'b000)
                wr_pend = 1'b1;
            busy_prev = mdu_if.busy;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;

        mdu_if.start    = 1'b0;
        mdu_if.MDOp     = 3'b000;
        mdu_if.MDWE     = 1'b0;
        mdu_if.MDAddrOp = 1'b0;
        mdu_if.A        = '0;
        mdu_if.B        = '0;

        #1;
        chk("reset_hi",   64'(mdu_if.HI),   64'd0);
        chk("reset_lo",   64'(mdu_if.LO),   64'd0);
        chk("reset_busy", 64'(mdu_if.busy), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // directed cases with literal expectations
        do_op(3'd2, 32'hFFFF_FFFF, 32'h2, "mult_neg1x2");
        chk("mult_hi_lit", 64'(mdu_if.HI), 64'hFFFF_FFFF);
        chk("mult_lo_lit", 64'(mdu_if.LO), 64'hFFFF_FFFE);

        do_op(3'd1, 32'hFFFF_FFFF, 32'h2, "multu_ffx2");
        chk("multu_hi_lit", 64'(mdu_if.HI), 64'h1);
        chk("multu_lo_lit", 64'(mdu_if.LO), 64'hFFFF_FFFE);

        do_op(3'd4, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
        chk("div_hi_lit", 64'(mdu_if.HI), 64'hFFFF_FFFF);
        chk("div_lo_lit", 64'(mdu_if.LO), 64'hFFFF_FFFD);

        do_op(3'd3, 32'h7, 32'h0, "divu_by0");
        chk("divu0_hi_lit", 64'(mdu_if.HI), 64'hFFFF_FFFF);
        chk("divu0_lo_lit", 64'(mdu_if.LO), 64'hFFFF_FFFD);

        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("ovf_hi_lit", 64'(mdu_if.HI), 64'h0);
        chk("ovf_lo_lit", 64'(mdu_if.LO), 64'h8000_0000);

        do_mt(1'b1, 32'h1234_5678, "mthi");
        mdu_if.MDAddrOp = 1'b1; #1;
        chk("rd_hi", 64'(mdu_if.rdData), 64'h1234_5678);
        mdu_if.MDAddrOp = 1'b0; #1;
        chk("rd_lo", 64'(mdu_if.rdData), 64'h8000_0000);

        // requests while busy must leave the op in flight alone
        begin
            exp_t e;
            void'(model_op(3'd2, 32'h3, 32'h4));
            e.hi = m_hi; e.lo = m_lo; e.lat = MULT_LAT; e.name = "mult_overlap";
            sb_q.push_back(e);
            drive(3'd2, 1'b0, 1'b0, 32'h3, 32'h4);
            drive(3'd1, 1'b0, 1'b0, 32'd100, 32'd100);   hz_expected++;
            drive(3'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0); hz_expected++;
            wait_idle("mult_overlap");
            chk("overlap_hi_lit", 64'(mdu_if.HI), 64'h0);
            chk("overlap_lo_lit", 64'(mdu_if.LO), 64'd12);
        end

        // async reset in the third busy cycle of a div
        begin
            exp_t e;
            e.hi = 32'h0; e.lo = 32'h0; e.lat = DIV_LAT; e.name = "div_aborted";
            sb_q.push_back(e);
            drive(3'd4, 1'b0, 1'b0, 32'd100, 32'd7);
            @(posedge clk); #1;
            @(posedge clk); #1;
            reset_n = 1'b0;
            #1;
            chk("abort_hi",   64'(mdu_if.HI),   64'd0);
            chk("abort_lo",   64'(mdu_if.LO),   64'd0);
            chk("abort_busy", 64'(mdu_if.busy), 64'd0);
            sb_q.delete();
            m_hi = '0;
            m_lo = '0;
            repeat (2) @(posedge clk);
            #1 reset_n = 1'b1;
            repeat (DIV_LAT + 2) @(posedge clk);
            #1;
            chk("abort_hi_late",   64'(mdu_if.HI),   64'd0);
            chk("abort_lo_late",   64'(mdu_if.LO),   64'd0);
            chk("abort_busy_late", 64'(mdu_if.busy), 64'd0);
        end

        do_op(3'd2, 32'h10, 32'h20, "mult_after_reset");
        chk("mar_lo_lit", 64'(mdu_if.LO), 64'h200);

        // madd with carry out of LO, or a no-op when the feature is absent
        do_mt(1'b1, 32'h0, "mthi0");
        do_mt(1'b0, 32'hFFFF_FFFF, "mtloff");
`ifdef MDU_MADD_EN
        do_op(3'd5, 32'h1, 32'h1, "madd");
        chk("madd_hi_lit", 64'(mdu_if.HI), 64'h1);
        chk("madd_lo_lit", 64'(mdu_if.LO), 64'h0);
`else
        begin
            bit seen_busy;
            seen_busy = 1'b0;
            drive(3'd5, 1'b0, 1'b0, 32'h1, 32'h1);
            for (int i = 0; i < MULT_LAT + 2; i++) begin
                if (mdu_if.busy) seen_busy = 1'b1;
                @(posedge clk); #1;
            end
            chk("op101_busy", 64'(seen_busy), 64'd0);
            chk("op101_hi",   64'(mdu_if.HI), 64'h0);
            chk("op101_lo",   64'(mdu_if.LO), 64'hFFFF_FFFF);
        end
`endif

        // randomized traffic, serialised the way the hazard unit would
        for (int n = 0; n < 30; n++) begin
            ra = pick();
            rb = pick();
            case ($urandom_range(0, 5))
                4: do_mt(1'($urandom_range(0, 1)), ra, "rnd_mt");
`ifdef MDU_MADD_EN
                5: begin
                    op = 3'($urandom_range(5, 6));
                    do_op(op, ra, rb, "rnd_madd");
                end
`endif
                default: begin
                    op = 3'($urandom_range(1, 4));
                    do_op(op, ra, rb, "rnd_op");
                end
            endcase
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("hazard_cnt", 64'(hz_seen),     64'(hz_expected));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
